riscv_hazard_sb: RTL and testbench

Parametrised hazard and stall controller for the in-order RISC-V pipeline. It keeps its own shadow copy of every in-flight instruction's destination register, one entry per stage downstream of decode. From that copy it generates per-boundary stall and flush strobes for branch redirects, memory-bus stalls and read-after-write hazards. It sits beside the datapath in the pipeline top and replaces fixed-depth hazard logic, so the pipeline depth can change without rewriting the controller.

---
 rtl/riscv_hazard_sb.sv | 163 ++++++++++++++++
 tb/tb_riscv_hazard_sb.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/riscv_hazard_sb.sv
// Hazard/stall controller with a shadow destination scoreboard, one entry per stage after decode.
// Optional operand forwarding selects are built when RISCV_HZD_FWD_EN is defined.
module riscv_hazard_sb #(
    parameter int unsigned NSTAGE    = 3,
    parameter int unsigned BR_STAGE  = 1,
    parameter int unsigned MEM_STAGE = 1,
    parameter int unsigned REG_AW    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_dec_valid,
    input  logic              i_src1_en,
    input  logic              i_src2_en,
    input  logic [REG_AW-1:0] i_src1_addr,
    input  logic [REG_AW-1:0] i_src2_addr,
    input  logic              i_dst_we,
    input  logic [REG_AW-1:0] i_dst_addr,
    input  logic              i_is_load,
    input  logic              i_redirect,
    input  logic              i_mem_stall,
    output logic              o_stall_f,
    output logic              o_stall_fd,
    output logic              o_flush_fd,
    output logic              o_flush_de,
    output logic [NSTAGE-1:0] o_stall_pipe,
    output logic [NSTAGE-1:0] o_flush_pipe,
    output logic              o_issue,
`ifdef RISCV_HZD_FWD_EN
    output logic [$clog2(NSTAGE+1)-1:0] o_fwd1_sel,
    output logic [$clog2(NSTAGE+1)-1:0] o_fwd2_sel,
`endif
    output logic [31:0]       o_hzd_cnt
);
    localparam int NS   = int'(NSTAGE);
    localparam int BRS  = int'(BR_STAGE);
    localparam int MEMS = int'(MEM_STAGE);

    logic [NSTAGE-1:0]             r_vld, r_we, r_ld;
    logic [NSTAGE-1:0][REG_AW-1:0] r_dst;
    logic [NSTAGE-1:0]             w_vld_d, w_we_d, w_ld_d;
    logic [NSTAGE-1:0][REG_AW-1:0] w_dst_d;
    logic [NSTAGE-1:0]             w_m1, w_m2;
    logic                          w_hzd, w_cnt_inc;
    logic [31:0]                   r_hzd_cnt;

    always_comb begin
        w_m1 = '0;
        w_m2 = '0;
        for (int k = 0; k < NS; k++) begin
            w_m1[k] = i_src1_en && (i_src1_addr != '0) && r_vld[k] && r_we[k]
                      && (r_dst[k] == i_src1_addr);
            w_m2[k] = i_src2_en && (i_src2_addr != '0) && r_vld[k] && r_we[k]
                      && (r_dst[k] == i_src2_addr);
        end
    end

`ifdef RISCV_HZD_FWD_EN
    localparam int SELW = $clog2(NSTAGE+1);

    // Lowest matching index is the youngest producer; encode as index + 1.
    function automatic logic [SELW-1:0] f_sel(input logic [NSTAGE-1:0] m);
        f_sel = '0;
        for (int k = NS - 1; k >= 0; k--) begin
            if (m[k]) f_sel = SELW'(k + 1);
        end
    endfunction

    assign o_fwd1_sel = i_dec_valid ? f_sel(w_m1) : '0;
    assign o_fwd2_sel = i_dec_valid ? f_sel(w_m2) : '0;
    // Only a load in stage 0 has no value to forward yet.
    assign w_hzd = i_dec_valid && (w_m1[0] || w_m2[0]) && r_ld[0];
`else
    logic w_unused_ld;
    assign w_unused_ld = ^r_ld;
    assign w_hzd = i_dec_valid && ((|w_m1) || (|w_m2));
`endif

    always_comb begin
        o_stall_f    = 1'b0;
        o_stall_fd   = 1'b0;
        o_flush_fd   = 1'b0;
        o_flush_de   = 1'b0;
        o_stall_pipe = '0;
        o_flush_pipe = '0;
        o_issue      = 1'b0;
        w_cnt_inc    = 1'b0;
        w_vld_d      = r_vld;
        w_we_d       = r_we;
        w_ld_d       = r_ld;
        w_dst_d      = r_dst;
        if (i_mem_stall) begin
            o_stall_f  = 1'b1;
            o_stall_fd = 1'b1;
            for (int k = 0; k < NS; k++) begin
                if (k <= MEMS) o_stall_pipe[k] = 1'b1;
            end
            for (int k = 1; k < NS; k++) begin
                if (k == MEMS + 1) begin
                    o_flush_pipe[k] = 1'b1;
                    w_vld_d[k]      = 1'b0;
                end else if (k > MEMS + 1) begin
                    w_vld_d[k] = r_vld[k-1];
                    w_we_d[k]  = r_we[k-1];
                    w_ld_d[k]  = r_ld[k-1];
                    w_dst_d[k] = r_dst[k-1];
                end
            end
        end else if (i_redirect) begin
            o_flush_fd = 1'b1;
            o_flush_de = 1'b1;
            for (int k = 1; k < NS; k++) begin
                if (k <= BRS) o_flush_pipe[k] = 1'b1;
            end
            // Wrong-path entries younger than the branch are killed as they shift.
            w_vld_d[0] = 1'b0;
            for (int k = 1; k < NS; k++) begin
                w_vld_d[k] = (k <= BRS) ? 1'b0 : r_vld[k-1];
                w_we_d[k]  = r_we[k-1];
                w_ld_d[k]  = r_ld[k-1];
                w_dst_d[k] = r_dst[k-1];
            end
        end else begin
            for (int k = 1; k < NS; k++) begin
                w_vld_d[k] = r_vld[k-1];
                w_we_d[k]  = r_we[k-1];
                w_ld_d[k]  = r_ld[k-1];
                w_dst_d[k] = r_dst[k-1];
            end
            if (w_hzd) begin
                o_stall_f  = 1'b1;
                o_stall_fd = 1'b1;
                o_flush_de = 1'b1;
                w_cnt_inc  = 1'b1;
                w_vld_d[0] = 1'b0;
            end else begin
                o_issue    = i_dec_valid;
                w_vld_d[0] = i_dec_valid;
                w_we_d[0]  = i_dst_we;
                w_ld_d[0]  = i_is_load;
                w_dst_d[0] = i_dst_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld     <= '0;
            r_we      <= '0;
            r_ld      <= '0;
            r_dst     <= '0;
            r_hzd_cnt <= '0;
        end else begin
            r_vld <= w_vld_d;
            r_we  <= w_we_d;
            r_ld  <= w_ld_d;
            r_dst <= w_dst_d;
            if (w_cnt_inc && (r_hzd_cnt != 32'hFFFF_FFFF)) r_hzd_cnt <= r_hzd_cnt + 32'd1;
        end
    end

    assign o_hzd_cnt = r_hzd_cnt;

endmodule

// File: tb/tb_riscv_hazard_sb.sv
// Directed table-driven bench for riscv_hazard_sb (NSTAGE=3, BR_STAGE=1, MEM_STAGE=1).
// Builds the forwarding sequence instead of the table when RISCV_HZD_FWD_EN is defined.
module tb_riscv_hazard_sb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_dec_valid, i_src1_en, i_src2_en, i_dst_we, i_is_load, i_redirect, i_mem_stall;
    logic [4:0]  i_src1_addr, i_src2_addr, i_dst_addr;
    logic        o_stall_f, o_stall_fd, o_flush_fd, o_flush_de, o_issue;
    logic [2:0]  o_stall_pipe, o_flush_pipe;
    logic [31:0] o_hzd_cnt;
`ifdef RISCV_HZD_FWD_EN
    logic [1:0]  o_fwd1_sel, o_fwd2_sel;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_hazard_sb #(
        .NSTAGE(3), .BR_STAGE(1), .MEM_STAGE(1), .REG_AW(5)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_dec_valid(i_dec_valid), .i_src1_en(i_src1_en), .i_src2_en(i_src2_en),
        .i_src1_addr(i_src1_addr), .i_src2_addr(i_src2_addr),
        .i_dst_we(i_dst_we), .i_dst_addr(i_dst_addr), .i_is_load(i_is_load),
        .i_redirect(i_redirect), .i_mem_stall(i_mem_stall),
        .o_stall_f(o_stall_f), .o_stall_fd(o_stall_fd), .o_flush_fd(o_flush_fd),
        .o_flush_de(o_flush_de), .o_stall_pipe(o_stall_pipe), .o_flush_pipe(o_flush_pipe),
        .o_issue(o_issue),
`ifdef RISCV_HZD_FWD_EN
        .o_fwd1_sel(o_fwd1_sel), .o_fwd2_sel(o_fwd2_sel),
`endif
        .o_hzd_cnt(o_hzd_cnt)
    );

    // {stall_f, stall_fd, flush_fd, flush_de, stall_pipe[2:0], flush_pipe[2:0], issue}
    localparam logic [10:0] IDLE = 11'b0000_000_000_0;
    localparam logic [10:0] ISS  = 11'b0000_000_000_1;
    localparam logic [10:0] HZD  = 11'b1101_000_000_0;
    localparam logic [10:0] RED  = 11'b0011_000_010_0;
    localparam logic [10:0] MEM  = 11'b1100_011_100_0;

    typedef struct {
        logic        dv, s1en;
        logic [4:0]  s1a;
        logic        s2en;
        logic [4:0]  s2a;
        logic        we;
        logic [4:0]  dst;
        logic        ld, rd, ms;
        logic [10:0] exp;
        logic [31:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic dv, input logic s1en, input logic [4:0] s1a,
                                input logic s2en, input logic [4:0] s2a, input logic we,
                                input logic [4:0] dst, input logic ld, input logic rd,
                                input logic ms, input logic [10:0] exp, input logic [31:0] cnt);
        vec_t v;
        v.dv = dv; v.s1en = s1en; v.s1a = s1a; v.s2en = s2en; v.s2a = s2a;
        v.we = we; v.dst = dst; v.ld = ld; v.rd = rd; v.ms = ms; v.exp = exp; v.cnt = cnt;
        return v;
    endfunction

    function automatic logic [10:0] strobes();
        return {o_stall_f, o_stall_fd, o_flush_fd, o_flush_de, o_stall_pipe, o_flush_pipe,
                o_issue};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        i_dec_valid = v.dv; i_src1_en = v.s1en; i_src1_addr = v.s1a;
        i_src2_en = v.s2en; i_src2_addr = v.s2a; i_dst_we = v.we; i_dst_addr = v.dst;
        i_is_load = v.ld; i_redirect = v.rd; i_mem_stall = v.ms;
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        drive(v);
        #1;
        check({name, ".strobes"}, {21'd0, strobes()}, {21'd0, v.exp});
        check({name, ".cnt"}, o_hzd_cnt, v.cnt);
    endtask

    vec_t tbl[20];

    initial begin
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 0));
        #12;
        check("reset.strobes", {21'd0, strobes()}, 32'd0);
        check("reset.cnt", o_hzd_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`ifndef RISCV_HZD_FWD_EN
        tbl[0]  = mk(0, 0, 0,  0, 0, 0, 0,  0, 0, 0, IDLE, 0);
        tbl[1]  = mk(1, 1, 0,  0, 0, 1, 5,  0, 0, 0, ISS,  0);  // addi x5
        tbl[2]  = mk(1, 1, 5,  1, 5, 1, 6,  0, 0, 0, HZD,  0);  // add x6,x5,x5
        tbl[3]  = mk(1, 1, 5,  1, 5, 1, 6,  0, 0, 0, HZD,  1);
        tbl[4]  = mk(1, 1, 5,  1, 5, 1, 6,  0, 0, 0, HZD,  2);
        tbl[5]  = mk(1, 1, 5,  1, 5, 1, 6,  0, 0, 0, ISS,  3);
        tbl[6]  = mk(1, 1, 0,  0, 0, 1, 0,  0, 0, 0, ISS,  3);  // writes x0
        tbl[7]  = mk(1, 1, 0,  1, 0, 0, 0,  0, 0, 0, ISS,  3);  // reads x0
        tbl[8]  = mk(1, 0, 0,  1, 6, 1, 9,  0, 0, 0, HZD,  3);  // x6 in stage 2
        tbl[9]  = mk(1, 0, 0,  1, 6, 1, 9,  0, 0, 0, ISS,  4);
        tbl[10] = mk(1, 1, 9,  0, 0, 1, 12, 0, 1, 0, RED,  4);  // redirect beats hazard
        tbl[11] = mk(1, 1, 9,  0, 0, 1, 10, 0, 0, 0, ISS,  4);  // x9 was killed
        tbl[12] = mk(1, 0, 0,  0, 0, 1, 11, 1, 0, 0, ISS,  4);
        for (int i = 13; i < 17; i++) tbl[i] = mk(1, 1, 11, 0, 0, 1, 13, 0, 1, 1, MEM, 4);
        tbl[17] = mk(1, 1, 11, 0, 0, 1, 13, 0, 1, 0, RED,  4);
        tbl[18] = mk(1, 1, 10, 0, 0, 1, 14, 0, 0, 0, HZD,  4);  // x10 moved to stage 2
        tbl[19] = mk(1, 1, 10, 0, 0, 1, 14, 0, 0, 0, ISS,  5);
        for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Hazard on x14 present, then asynchronous reset mid-cycle drops it.
        apply(mk(1, 1, 14, 0, 0, 0, 0, 0, 0, 0, HZD, 5), "prerst");
        @(negedge clk);
        #1;
        check("prerst.cnt", o_hzd_cnt, 32'd6);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 0));
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst.strobes", {21'd0, strobes()}, 32'd0);
        check("midrst.cnt", o_hzd_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(1, 1, 14, 0, 0, 0, 0, 0, 0, 0, ISS, 0), "postrst");
`else
        apply(mk(1, 1, 0, 0, 0, 1, 5, 0, 0, 0, ISS, 0), "f_addi");
        check("f_addi.fwd1", {30'd0, o_fwd1_sel}, 32'd0);
        apply(mk(1, 1, 5, 0, 0, 1, 6, 0, 0, 0, ISS, 0), "f_use1");
        check("f_use1.fwd1", {30'd0, o_fwd1_sel}, 32'd1);
        apply(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, ISS, 0), "f_use2");
        check("f_use2.fwd1", {30'd0, o_fwd1_sel}, 32'd2);
        apply(mk(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, ISS, 0), "f_load");
        apply(mk(1, 1, 7, 0, 0, 1, 8, 0, 0, 0, HZD, 0), "f_ldu");
        check("f_ldu.fwd1", {30'd0, o_fwd1_sel}, 32'd1);
        apply(mk(1, 1, 7, 0, 0, 1, 8, 0, 0, 0, ISS, 1), "f_ldu2");
        check("f_ldu2.fwd1", {30'd0, o_fwd1_sel}, 32'd2);
        apply(mk(0, 1, 8, 0, 0, 0, 0, 0, 0, 0, IDLE, 1), "f_inv");
        check("f_inv.fwd1", {30'd0, o_fwd1_sel}, 32'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
